sys_ctrl: RTL and testbench

- Command-level system controller on the reference-clock side of the UART path.
- Consumes the synchronized received byte stream from the UART receiver (via the data synchronizer) and decodes framed commands.
- Drives register-file writes and reads, and ALU operations with ALU clock-gate enable.
- Pushes response bytes into the TX async FIFO, which feeds the UART transmitter.

---
 rtl/sys_pkg.sv | 14 +
 rtl/sys_ctrl.sv | 143 ++++++++++++++
 tb/tb_sys_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_pkg.sv
// sys_pkg: shared widths, command codes and controller state encoding
package sys_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int FUN_WIDTH = 4;
  localparam logic [7:0] CMD_RF_WR = 8'hAA;
  localparam logic [7:0] CMD_RF_RD = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_RD_SEND,
    ST_ALU_A, ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT, ST_SEND_LO, ST_SEND_HI
  } state_t;
endpackage

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes framed UART commands into register-file, ALU and TX FIFO traffic
module sys_ctrl #(
  parameter int DATA_WIDTH = sys_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sys_pkg::ADDR_WIDTH,
  parameter int FUN_WIDTH = sys_pkg::FUN_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_WR = sys_pkg::CMD_RF_WR,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_RD = sys_pkg::CMD_RF_RD,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP = sys_pkg::CMD_ALU_OP,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = sys_pkg::CMD_ALU_NOP
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);
  import sys_pkg::*;
  state_t state, state_d;
  logic [2*DATA_WIDTH-1:0] res, res_d;
  logic wr_en_d, rd_en_d, alu_en_d, clk_en_d, tx_vld_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0] fun_d;
  // next state and next value of every registered output; strobes default low, data outputs hold
  always_comb begin
    state_d = state;
    res_d = res;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    alu_en_d = 1'b0;
    tx_vld_d = 1'b0;
    clk_en_d = CLK_EN;
    addr_d = Address;
    wr_data_d = WrData;
    fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;
    case (state)
      ST_IDLE: if (RX_D_VLD)
        state_d = RX_P_DATA == CMD_RF_WR   ? ST_WR_ADDR :
                  RX_P_DATA == CMD_RF_RD   ? ST_RD_ADDR :
                  RX_P_DATA == CMD_ALU_OP  ? ST_ALU_A   :
                  RX_P_DATA == CMD_ALU_NOP ? ST_ALU_FUN : ST_IDLE;
      ST_WR_ADDR: if (RX_D_VLD) begin
        addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (RdData_Valid) begin
        res_d = {{DATA_WIDTH{1'b0}}, RdData};
        state_d = ST_RD_SEND;
      end
      ST_RD_SEND: if (!FIFO_FULL) begin
        tx_data_d = res[DATA_WIDTH-1:0];
        tx_vld_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ALU_A: if (RX_D_VLD) begin
        addr_d = '0;
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = ST_ALU_B;
      end
      ST_ALU_B: if (RX_D_VLD) begin
        addr_d = ADDR_WIDTH'(1);
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (RX_D_VLD) begin
        fun_d = RX_P_DATA[FUN_WIDTH-1:0];
        alu_en_d = 1'b1;
        clk_en_d = 1'b1;
        state_d = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (OUT_Valid) begin
        res_d = ALU_OUT;
        clk_en_d = 1'b0;
        state_d = ST_SEND_LO;
      end
      ST_SEND_LO: if (!FIFO_FULL) begin
        tx_data_d = res[DATA_WIDTH-1:0];
        tx_vld_d = 1'b1;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: if (!FIFO_FULL) begin
        tx_data_d = res[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_vld_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state, result latch and all outputs registered; reset aborts any frame in progress
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      res <= '0;
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      Address <= '0;
      WrData <= '0;
      ALU_EN <= 1'b0;
      ALU_FUN <= '0;
      CLK_EN <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD <= 1'b0;
    end else begin
      state <= state_d;
      res <= res_d;
      WrEn <= wr_en_d;
      RdEn <= rd_en_d;
      Address <= addr_d;
      WrData <= wr_data_d;
      ALU_EN <= alu_en_d;
      ALU_FUN <= fun_d;
      CLK_EN <= clk_en_d;
      TX_P_DATA <= tx_data_d;
      TX_D_VLD <= tx_vld_d;
    end
  end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: randomized frames checked against an event-level model of the controller
module tb_sys_ctrl;
  logic CLK = 1'b0;
  logic RST;
  logic [7:0] RX_P_DATA, RdData;
  logic RX_D_VLD, RdData_Valid, OUT_Valid, FIFO_FULL;
  logic [15:0] ALU_OUT;
  logic WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData, TX_P_DATA;
  int checks = 0, errors = 0;
  int tx_when_full = 0;
  logic full_at_edge = 1'b0;
  logic [23:0] ev_q[$];
  logic [23:0] exp_q[$];

  always #5 CLK = ~CLK;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  // FIFO_FULL as the DUT saw it at the edge that produced the current outputs
  always @(posedge CLK) full_at_edge <= FIFO_FULL;

  // observed strobe events, one entry per strobe cycle
  always @(negedge CLK) if (RST) begin
    if (WrEn) ev_q.push_back({8'h01, 4'h0, Address, WrData});
    if (RdEn) ev_q.push_back({8'h02, 4'h0, Address, 8'h00});
    if (ALU_EN) ev_q.push_back({8'h03, 3'b000, CLK_EN, ALU_FUN, 8'h00});
    if (TX_D_VLD) begin
      ev_q.push_back({16'h0400, TX_P_DATA});
      if (full_at_edge) tx_when_full++;
    end
  end

  function automatic logic [28:0] outs();
    return {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD};
  endfunction

  // expected strobe sequence of one whole frame
  function automatic void model_frame(input logic [7:0] cmd, a, b, f, rdata, input logic [15:0] res);
    case (cmd)
      8'hAA: exp_q.push_back({8'h01, 4'h0, a[3:0], b});
      8'hBB: begin
        exp_q.push_back({8'h02, 4'h0, a[3:0], 8'h00});
        exp_q.push_back({16'h0400, rdata});
      end
      8'hCC, 8'hDD: begin
        if (cmd == 8'hCC) begin
          exp_q.push_back({12'h010, 4'h0, a});
          exp_q.push_back({12'h010, 4'h1, b});
        end
        exp_q.push_back({8'h03, 4'h1, f[3:0], 8'h00});
        exp_q.push_back({16'h0400, res[7:0]});
        exp_q.push_back({16'h0400, res[15:8]});
      end
      default: ;
    endcase
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) step;
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    step;
    RX_D_VLD = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic respond_rd(input logic [7:0] rdata, input int stall);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!RdEn && n < 20);
    if (!RdEn) begin
      checks++; errors++;
      $display("FAIL rd_strobe: RdEn got 0 required 1 within 20 cycles");
      return;
    end
    step;
    RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1; ALU_OUT = 16'($urandom); OUT_Valid = 1'b1;
    step;
    RX_D_VLD = 1'b0; OUT_Valid = 1'b0; RdData = rdata; RdData_Valid = 1'b1; FIFO_FULL = stall > 0;
    step;
    RdData_Valid = 1'b0; RdData = 8'($urandom);
    repeat (stall) step;
    FIFO_FULL = 1'b0;
  endtask

  task automatic respond_alu(input logic [15:0] res, input int stall);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!ALU_EN && n < 20);
    if (!ALU_EN) begin
      checks++; errors++;
      $display("FAIL alu_strobe: ALU_EN got 0 required 1 within 20 cycles");
      return;
    end
    step;
    RX_P_DATA = 8'hBB; RX_D_VLD = 1'b1; RdData = 8'($urandom); RdData_Valid = 1'b1;
    step;
    RX_D_VLD = 1'b0; RdData_Valid = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      checks++;
      if (CLK_EN !== 1'b1) begin errors++; $display("FAIL clk_en_wait: CLK_EN got %b required 1", CLK_EN); end
      step;
    end
    OUT_Valid = 1'b1; ALU_OUT = res; FIFO_FULL = stall > 0;
    checks++;
    if (CLK_EN !== 1'b1) begin errors++; $display("FAIL clk_en_capture: CLK_EN got %b required 1", CLK_EN); end
    step;
    OUT_Valid = 1'b0; ALU_OUT = 16'($urandom);
    checks++;
    if (CLK_EN !== 1'b0) begin errors++; $display("FAIL clk_en_release: CLK_EN got %b required 0", CLK_EN); end
    repeat (stall) step;
    FIFO_FULL = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [7:0] cmd, a, b, f, rdata,
                         input logic [15:0] res, input int stall);
    int n = 0;
    int base = ev_q.size();
    int full_base = tx_when_full;
    exp_q.delete();
    model_frame(cmd, a, b, f, rdata, res);
    send(cmd);
    if (cmd == 8'hAA) begin send(a); send(b); end
    else if (cmd == 8'hBB) begin send(a); respond_rd(rdata, stall); end
    else if (cmd == 8'hCC) begin send(a); send(b); send(f); respond_alu(res, stall); end
    else if (cmd == 8'hDD) begin send(f); respond_alu(res, stall); end
    while (ev_q.size() - base < exp_q.size() && n < 100) begin step; n++; end
    repeat (4) step;
    checks++;
    if (ev_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d required %0d", name, ev_q.size() - base, exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (ev_q[base + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s event%0d: got %h required %h", name, i, ev_q[base + i], exp_q[i]);
      end
    end
    checks++;
    if (tx_when_full != full_base) begin
      errors++;
      $display("FAIL %s tx_while_full: got %0d pushes required 0", name, tx_when_full - full_base);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
    ALU_OUT = '0; OUT_Valid = 1'b0; FIFO_FULL = 1'b0;
    #2;
    checks++;
    if (outs() !== 29'd0) begin errors++; $display("FAIL reset_hold: outputs got %h required 0", outs()); end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    step;
    checks++;
    if (outs() !== 29'd0) begin errors++; $display("FAIL reset_release: outputs got %h required 0", outs()); end
  endtask

  task automatic test_wr;
    run_cmd("wr", 8'hAA, 8'h05, 8'h3C, 8'h00, 8'h00, 16'h0000, 0);
    checks++;
    if ({Address, WrData} !== 12'h53C) begin
      errors++; $display("FAIL wr_hold: Address/WrData got %h required 53c", {Address, WrData});
    end
  endtask

  task automatic test_rd;
    run_cmd("rd", 8'hBB, 8'h05, 8'h00, 8'h00, 8'h3C, 16'h0000, 0);
  endtask

  task automatic test_alu;
    run_cmd("alu", 8'hCC, 8'h07, 8'h03, 8'h00, 8'h00, 16'h000A, 0);
  endtask

  task automatic test_nop_backpressure;
    run_cmd("nop_bp", 8'hDD, 8'h00, 8'h00, 8'h02, 8'h00, 16'h1234, 5);
    checks++;
    if (ALU_FUN !== 4'h2) begin errors++; $display("FAIL fun_hold: ALU_FUN got %h required 2", ALU_FUN); end
  endtask

  task automatic test_illegal_midreset;
    int base;
    run_cmd("illegal", 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0);
    send(8'hAA);
    send(8'h05);
    checks++;
    if (Address !== 4'h5) begin errors++; $display("FAIL midframe_addr: Address got %h required 5", Address); end
    #3 RST = 1'b0;
    #1;
    checks++;
    if (outs() !== 29'd0) begin errors++; $display("FAIL midframe_reset: outputs got %h required 0", outs()); end
    step;
    RST = 1'b1;
    base = ev_q.size();
    send(8'h3C);
    repeat (4) step;
    checks++;
    if (ev_q.size() != base) begin
      errors++; $display("FAIL after_reset_byte: got %0d events required 0", ev_q.size() - base);
    end
    run_cmd("after_reset", 8'hAA, 8'h09, 8'h5A, 8'h00, 8'h00, 16'h0000, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] cmd;
      int sel;
      sel = $urandom_range(0, 4);
      cmd = sel == 0 ? 8'hAA : sel == 1 ? 8'hBB : sel == 2 ? 8'hCC : sel == 3 ? 8'hDD : 8'($urandom);
      if (sel == 4 && (cmd == 8'hAA || cmd == 8'hBB || cmd == 8'hCC || cmd == 8'hDD)) cmd = 8'h00;
      run_cmd($sformatf("rand%0d", i), cmd, 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 16'($urandom), $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset;
    test_wr;
    test_rd;
    test_alu;
    test_nop_backpressure;
    test_illegal_midreset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
